// File: rtl/light_phase_timer.sv
// Traffic-light phase timer: RED -> GREEN -> YELLOW loop with
// per-phase BCD durations and a BCD countdown display.
module light_phase_timer #(
  parameter int DIGITS           = 2,
  parameter bit CLEAR_ON_DISABLE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   red_time,
  input  logic [4*DIGITS-1:0]   green_time,
  input  logic [4*DIGITS-1:0]   yellow_time,
  output logic [4*DIGITS-1:0]   cnt,
  output logic [1:0]            phase,
  output logic [2:0]            lamp,
  output logic                  phase_done,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   cnt_n;
  logic [W-1:0]   dur;
  logic           load;
  logic           done_n;
  logic           err_n;

  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  function automatic logic any_bad(input logic [W-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  // Borrow ripples upward through zero digits only.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_n   = err;
    dur     = '0;
    load    = 1'b0;
    if (!enable) begin
      if (CLEAR_ON_DISABLE) begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end else if (state == IDLE) begin
      state_n = RED;
      dur     = red_time;
      load    = 1'b1;
    end else if (cnt != '0) begin
      cnt_n = bcd_dec(cnt);
    end else begin
      done_n = 1'b1;
      load   = 1'b1;
      unique case (state)
        RED: begin
          state_n = GREEN;
          dur     = green_time;
        end
        GREEN: begin
          state_n = YELLOW;
          dur     = yellow_time;
        end
        YELLOW: begin
          state_n = RED;
          dur     = red_time;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
    if (load) begin
      cnt_n = sanitize(dur);
      if (any_bad(dur)) err_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      phase_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      phase_done <= done_n;
      err        <= err_n;
    end
  end

  assign phase = state;

  // Lamps follow the phase register only, so cnt cannot glitch them.
  always_comb begin
    lamp = 3'b100;
    unique case (state)
      GREEN:   lamp = 3'b001;
      YELLOW:  lamp = 3'b010;
      default: lamp = 3'b100;
    endcase
  end

endmodule

// File: tb/tb_light_phase_timer.sv
// Bench for light_phase_timer: two instances (2-digit hold mode,
// 3-digit clear mode) checked each cycle against a decimal model.
module tb_light_phase_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [7:0]  r2, g2, y2;
  logic [11:0] r3, g3, y3;
  logic [7:0]  cnt0;
  logic [11:0] cnt1;
  logic [1:0]  ph0, ph1;
  logic [2:0]  lamp0, lamp1;
  logic        dn0, dn1, er0, er1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  light_phase_timer #(.DIGITS(2), .CLEAR_ON_DISABLE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .enable(en),
    .red_time(r2), .green_time(g2), .yellow_time(y2),
    .cnt(cnt0), .phase(ph0), .lamp(lamp0),
    .phase_done(dn0), .err(er0)
  );

  light_phase_timer #(.DIGITS(3), .CLEAR_ON_DISABLE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .enable(en),
    .red_time(r3), .green_time(g3), .yellow_time(y3),
    .cnt(cnt1), .phase(ph1), .lamp(lamp1),
    .phase_done(dn1), .err(er1)
  );

  // Model state: phase number and remaining time as a plain integer.
  typedef struct {
    int ph;
    int v;
    bit dn;
    bit er;
  } mst_t;

  mst_t a, b;

  function automatic int dval(logic [15:0] d, int nd);
    int v, m, nib;
    v = 0;
    m = 1;
    for (int i = 0; i < nd; i++) begin
      nib = int'(d[4*i +: 4]);
      v   = v + ((nib > 9) ? 9 : nib) * m;
      m   = m * 10;
    end
    return v;
  endfunction

  function automatic bit dbad(logic [15:0] d, int nd);
    bit x;
    x = 1'b0;
    for (int i = 0; i < nd; i++)
      if (d[4*i +: 4] > 4'd9) x = 1'b1;
    return x;
  endfunction

  function automatic logic [15:0] to_bcd(int v, int nd);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] lamp_of(int ph);
    return (ph == 2) ? 3'b001 : (ph == 3) ? 3'b010 : 3'b100;
  endfunction

  function automatic mst_t mstep(mst_t s, bit e, bit cod,
                                 logic [15:0] r, logic [15:0] g,
                                 logic [15:0] y, int nd);
    mst_t n;
    logic [15:0] d;
    n    = s;
    n.dn = 1'b0;
    if (!e) begin
      if (cod) begin
        n.ph = 0;
        n.v  = 0;
      end
      return n;
    end
    if (s.ph != 0 && s.v > 0) begin
      n.v = s.v - 1;
      return n;
    end
    n.ph = (s.ph == 0 || s.ph == 3) ? 1 : s.ph + 1;
    n.dn = (s.ph != 0);
    d    = (n.ph == 1) ? r : (n.ph == 2) ? g : y;
    n.v  = dval(d, nd);
    if (dbad(d, nd)) n.er = 1'b1;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '{0, 0, 1'b0, 1'b0};
      b <= '{0, 0, 1'b0, 1'b0};
    end else begin
      a <= mstep(a, en, 1'b0, {8'h0, r2}, {8'h0, g2}, {8'h0, y2}, 2);
      b <= mstep(b, en, 1'b1, {4'h0, r3}, {4'h0, g3}, {4'h0, y3}, 3);
    end
  end

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for condition", nm);
  endtask

  task automatic cmp_all();
    chk("d0 cnt",   16'(cnt0),  to_bcd(a.v, 2));
    chk("d0 phase", 16'(ph0),   16'(a.ph));
    chk("d0 lamp",  16'(lamp0), 16'(lamp_of(a.ph)));
    chk("d0 done",  16'(dn0),   16'(a.dn));
    chk("d0 err",   16'(er0),   16'(a.er));
    chk("d1 cnt",   16'(cnt1),  to_bcd(b.v, 3));
    chk("d1 phase", 16'(ph1),   16'(b.ph));
    chk("d1 lamp",  16'(lamp1), 16'(lamp_of(b.ph)));
    chk("d1 done",  16'(dn1),   16'(b.dn));
    chk("d1 err",   16'(er1),   16'(b.er));
  endtask

  task automatic cyc();
    @(negedge clk);
    cmp_all();
  endtask

  function automatic logic [15:0] rnd_dur(int nd);
    logic [15:0] d;
    int k;
    d = '0;
    d[3:0] = 4'($urandom_range(0, 9));
    d[7:4] = 4'($urandom_range(0, 2));
    if ($urandom_range(0, 11) == 0) begin
      k = $urandom_range(0, nd - 1);
      d[4*k +: 4] = 4'($urandom_range(10, 15));
    end
    return d;
  endfunction

  initial begin
    int i;
    r2 = 8'h29;   g2 = 8'h15;   y2 = 8'h03;
    r3 = 12'h100; g3 = 12'h015; y3 = 12'h003;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("reset lamp", 16'(lamp0), 16'h4);
    chk("reset cnt",  16'(cnt0),  16'h0);

    // Full loop; the 3-digit instance runs RED 100..000.
    en = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      cyc();
      if (k == 1) begin
        chk("entry cnt",  16'(cnt0), 16'h29);
        chk("entry done", 16'(dn0),  16'h0);
        chk("d3 entry",   16'(cnt1), 16'h100);
      end
      if (k == 2)  chk("d3 borrow", 16'(cnt1), 16'h099);
      if (k == 30) chk("red end", 16'(cnt0), 16'h00);
      if (k == 31) begin
        chk("green ph",   16'(ph0),   16'h2);
        chk("green cnt",  16'(cnt0),  16'h15);
        chk("green done", 16'(dn0),   16'h1);
        chk("green lamp", 16'(lamp0), 16'h1);
      end
      if (k == 32) chk("done width", 16'(dn0), 16'h0);
      if (k == 47) chk("yel lamp", 16'(lamp0), 16'h2);
      if (k == 51) chk("red again", 16'(cnt0), 16'h29);
      if (k == 101) chk("d3 red end", 16'(cnt1), 16'h000);
      if (k == 102) chk("d3 green", 16'(ph1), 16'h2);
    end

    // Disable hold (d0) versus clear (d1).
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (i = 0; i < 40 && cnt0 != 8'h17; i++) cyc();
    if (cnt0 != 8'h17) tmo("reach 17");
    en = 1'b0;
    repeat (5) cyc();
    chk("hold cnt",   16'(cnt0), 16'h17);
    chk("hold phase", 16'(ph0),  16'h1);
    chk("clr phase",  16'(ph1),  16'h0);
    en = 1'b1;
    cyc();
    chk("resume cnt", 16'(cnt0), 16'h16);
    chk("clr reload", 16'(cnt1), 16'h100);

    // Invalid yellow, mid-phase green change, zero yellow.
    y2 = 8'h3C;
    for (i = 0; i < 40 && ph0 != 2'd2; i++) cyc();
    if (ph0 != 2'd2) tmo("reach green");
    chk("green load", 16'(cnt0), 16'h15);
    g2 = 8'h77;
    cyc();
    chk("green ignore", 16'(cnt0), 16'h14);
    for (i = 0; i < 40 && ph0 != 2'd3; i++) cyc();
    if (ph0 != 2'd3) tmo("reach yellow");
    chk("bad nibble", 16'(cnt0), 16'h39);
    chk("err set",    16'(er0),  16'h1);
    y2 = 8'h00;
    g2 = 8'h05;
    for (i = 0; i < 60 && ph0 != 2'd1; i++) cyc();
    for (i = 0; i < 60 && ph0 != 2'd3; i++) cyc();
    if (ph0 != 2'd3) tmo("reach yellow0");
    cyc();
    chk("yel 1cyc",   16'(ph0), 16'h1);
    chk("err sticky", 16'(er0), 16'h1);

    // Asynchronous reset mid-GREEN.
    g2 = 8'h15;
    for (i = 0; i < 200 && !(ph0 == 2'd2 && cnt0 == 8'h07); i++) cyc();
    if (!(ph0 == 2'd2 && cnt0 == 8'h07)) tmo("reach g07");
    #2 rst = 1'b1;
    #1;
    chk("arst phase", 16'(ph0),   16'h0);
    chk("arst cnt",   16'(cnt0),  16'h0);
    chk("arst lamp",  16'(lamp0), 16'h4);
    chk("arst err",   16'(er0),   16'h0);
    cyc();
    rst = 1'b0;

    // Randomised run against the model.
    for (int k = 0; k < 3000; k++) begin
      cyc();
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      r2  = rnd_dur(2)[7:0];
      g2  = rnd_dur(2)[7:0];
      y2  = rnd_dur(2)[7:0];
      r3  = rnd_dur(3)[11:0];
      g3  = rnd_dur(3)[11:0];
      y3  = rnd_dur(3)[11:0];
    end
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
